// File: rtl/sdram_write.sv
// rtl/sdram_write.sv - full-page SDRAM write-burst sequencer (ACTIVE/WRITE/data/BST/PRECHARGE).
// Optional SDRAM_WR_STATS_EN adds wr_busy_o and wr_burst_cnt_o.
module sdram_write #(
  parameter int TRCD_CLK = 2,
  parameter int TWR_CLK  = 2,
  parameter int TRP_CLK  = 2
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [23:0] wr_addr_i,
  input  logic [9:0]  wr_burst_len_i,
  input  logic [15:0] wr_data_i,
  output logic        wr_ack_o,
  output logic        wr_end_o,
  output logic [3:0]  write_cmd_o,
  output logic [1:0]  write_ba_o,
  output logic [12:0] write_addr_o,
  output logic        wr_sdram_en_o,
  output logic [15:0] wr_sdram_data_o
`ifdef SDRAM_WR_STATS_EN
  ,
  output logic        wr_busy_o,
  output logic [15:0] wr_burst_cnt_o
`endif
);

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_BST = 4'b0110;
  localparam logic [3:0] CMD_PRE = 4'b0010;

  localparam logic [9:0] TRCD_LAST = 10'(TRCD_CLK - 1);
  localparam logic [9:0] TWR_LAST  = 10'(TWR_CLK - 1);
  localparam logic [9:0] TRP_LAST  = 10'(TRP_CLK - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ACTIVE, S_TRCD, S_WRITE, S_DATA,
    S_BST, S_TWR, S_PRE, S_TRP, S_END
  } state_t;

  state_t      state_q;
  logic [9:0]  cnt_q;
  logic [1:0]  bank_q;
  logic [12:0] row_q;
  logic [8:0]  col_q;
  logic [9:0]  len_q;
  logic [9:0]  len_clamped;

  always_comb begin
    if (wr_burst_len_i == 10'd0)
      len_clamped = 10'd1;
    else if (wr_burst_len_i > 10'd512)
      len_clamped = 10'd512;
    else
      len_clamped = wr_burst_len_i;
  end

  // Column overflow is left to the device: a full-page burst wraps inside the open row.
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      len_q   <= 10'd1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (wr_en_i) begin
            bank_q  <= wr_addr_i[23:22];
            row_q   <= wr_addr_i[21:9];
            col_q   <= wr_addr_i[8:0];
            len_q   <= len_clamped;
            state_q <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          cnt_q   <= '0;
          state_q <= S_TRCD;
        end
        S_TRCD: begin
          if (cnt_q == TRCD_LAST) state_q <= S_WRITE;
          else                    cnt_q   <= cnt_q + 10'd1;
        end
        S_WRITE: begin
          cnt_q   <= '0;
          state_q <= (len_q == 10'd1) ? S_BST : S_DATA;
        end
        S_DATA: begin
          if (cnt_q == len_q - 10'd2) state_q <= S_BST;
          else                        cnt_q   <= cnt_q + 10'd1;
        end
        S_BST: begin
          cnt_q   <= '0;
          state_q <= S_TWR;
        end
        S_TWR: begin
          if (cnt_q == TWR_LAST) state_q <= S_PRE;
          else                   cnt_q   <= cnt_q + 10'd1;
        end
        S_PRE: begin
          cnt_q   <= '0;
          state_q <= S_TRP;
        end
        S_TRP: begin
          if (cnt_q == TRP_LAST) state_q <= S_END;
          else                   cnt_q   <= cnt_q + 10'd1;
        end
        S_END:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    write_cmd_o     = CMD_NOP;
    write_ba_o      = 2'b11;
    write_addr_o    = 13'h1FFF;
    wr_ack_o        = 1'b0;
    wr_end_o        = 1'b0;
    wr_sdram_en_o   = 1'b0;
    wr_sdram_data_o = 16'h0000;
    case (state_q)
      S_ACTIVE: begin
        write_cmd_o  = CMD_ACT;
        write_ba_o   = bank_q;
        write_addr_o = row_q;
      end
      S_WRITE: begin
        write_cmd_o     = CMD_WR;
        write_ba_o      = bank_q;
        write_addr_o    = {4'b0000, col_q};
        wr_ack_o        = 1'b1;
        wr_sdram_en_o   = 1'b1;
        wr_sdram_data_o = wr_data_i;
      end
      S_DATA: begin
        wr_ack_o        = 1'b1;
        wr_sdram_en_o   = 1'b1;
        wr_sdram_data_o = wr_data_i;
      end
      S_BST: write_cmd_o = CMD_BST;
      S_PRE: begin
        write_cmd_o  = CMD_PRE;
        write_ba_o   = bank_q;
        write_addr_o = 13'h0400;
      end
      S_END:   wr_end_o = 1'b1;
      default: ;
    endcase
  end

`ifdef SDRAM_WR_STATS_EN
  logic [15:0] burst_cnt_q;

  always_ff @(posedge sys_clk_i) begin
    if (rst_i)                 burst_cnt_q <= 16'h0000;
    else if (state_q == S_END) burst_cnt_q <= burst_cnt_q + 16'h0001;
  end

  assign wr_busy_o      = (state_q != S_IDLE);
  assign wr_burst_cnt_o = burst_cnt_q;
`endif

endmodule
